static_frame_writer: RTL and testbench

STATIC_FRAME_WRITER -- requirements
Module: static_frame_writer

---
 rtl/static_frame_writer.sv | 143 ++++++++++++++
 tb/tb_static_frame_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/static_frame_writer.sv
// static_frame_writer
//   Captures one frame of pixels into a BRAM, then freezes it (HOLD) until the
//   downstream correlator has finished its search (tracking_mode=1) or right
//   after a short guard period (tracking_mode=0).
//
// Optional feature macro: STATIC_FRAME_WRITER_DROP_CNT_EN
//   defined   -> frames_dropped counts sof pulses seen in HOLD (saturating)
//   undefined -> frames_dropped tied to 0, no counter is built
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   pix_valid/data/sof    incoming pixel stream (sof only meaningful with valid)
//   tracking_mode         1 = stay in HOLD until max_ready after the guard
//   max_ready             correlator search-complete level
//   static_write_*        registered BRAM write port
//   static_bram_rdy       frozen frame available in BRAM
//   sof_err               1-cycle pulse when a capture restarts on an early sof
//   frames_dropped        frames skipped while frozen
module static_frame_writer #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int PIX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sof,
  input  logic             tracking_mode,
  input  logic             max_ready,
  output logic [18:0]      static_write_address,
  output logic [PIX_W-1:0] static_write_data,
  output logic             static_write_en,
  output logic             static_bram_rdy,
  output logic             sof_err,
  output logic [15:0]      frames_dropped
);

  localparam int NPIX = FRAME_W * FRAME_H;
  localparam int CW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    guard, guard_nxt;
  logic          sof_pix;

  logic          wr_en_d, rdy_d, sof_err_d;
  logic [CW-1:0] wr_addr_d;

  assign sof_pix = pix_valid & pix_sof;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      guard <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      guard <= guard_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    guard_nxt = guard;
    case (state)
      IDLE: begin
        if (sof_pix) begin
          state_nxt = CAPTURE;
          count_nxt = CW'(1);
        end
      end
      CAPTURE: begin
        // An sof mid-capture restarts the frame; its pixel lands at address 0.
        if (sof_pix)        count_nxt = CW'(1);
        else if (pix_valid) count_nxt = count + CW'(1);
      end
      HOLD: begin
        // The guard masks max_ready left over from the previous search.
        if (guard != 2'd2) begin
          guard_nxt = guard + 2'd1;
        end else if (!tracking_mode || max_ready) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
    // Frame full: freeze. Checked on count_nxt so a 1-pixel frame also works.
    if (state != HOLD && count_nxt == CW'(NPIX)) begin
      state_nxt = HOLD;
      guard_nxt = '0;
    end
  end

  // Output decode (registered below)
  always_comb begin
    wr_en_d   = (state == IDLE && sof_pix) || (state == CAPTURE && pix_valid);
    wr_addr_d = sof_pix ? '0 : count;
    sof_err_d = (state == CAPTURE) && sof_pix;
    // Rises one cycle after the final write strobe, drops on the exit edge.
    rdy_d     = (state == HOLD) && (state_nxt == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      static_write_en      <= 1'b0;
      static_write_address <= '0;
      static_write_data    <= '0;
      static_bram_rdy      <= 1'b0;
      sof_err              <= 1'b0;
    end else begin
      static_write_en      <= wr_en_d;
      static_write_address <= 19'(wr_addr_d);
      static_write_data    <= pix_data;
      static_bram_rdy      <= rdy_d;
      sof_err              <= sof_err_d;
    end
  end

`ifdef STATIC_FRAME_WRITER_DROP_CNT_EN
  logic [15:0] drop_cnt;
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (state == HOLD && sof_pix && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
  assign frames_dropped = drop_cnt;
`else
  assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_static_frame_writer.sv
module tb_static_frame_writer;
  localparam int FW = 8;
  localparam int FH = 4;
  localparam int N  = FW * FH;

`ifdef STATIC_FRAME_WRITER_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, pix_valid, pix_sof, tracking_mode, max_ready;
  logic [3:0]  pix_data;
  logic [18:0] static_write_address;
  logic [3:0]  static_write_data;
  logic        static_write_en, static_bram_rdy, sof_err;
  logic [15:0] frames_dropped;

  static_frame_writer #(.FRAME_W(FW), .FRAME_H(FH), .PIX_W(4)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .tracking_mode(tracking_mode), .max_ready(max_ready),
    .static_write_address(static_write_address), .static_write_data(static_write_data),
    .static_write_en(static_write_en), .static_bram_rdy(static_bram_rdy),
    .sof_err(sof_err), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [3:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0, errors = 0, n_writes = 0;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (static_write_en === 1'b1) begin
      n_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write",
                 static_write_address, static_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (static_write_address !== mon_e.addr || static_write_data !== mon_e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   static_write_address, static_write_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] d, input logic s);
    pix_valid = v;
    pix_data  = d;
    pix_sof   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'($urandom), 1'($urandom));
  endtask

  task automatic expect_wr(input int a, input int d);
    wr_t w;
    w.addr = 19'(a);
    w.data = 4'(d);
    exp_q.push_back(w);
  endtask

  // Sends one full frame starting with sof; optional idle gap after each pixel.
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < N; i++) begin
      expect_wr(i, i % 16);
      drive(1'b1, 4'(i % 16), i == 0);
      if (gaps && i != N - 1) idle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tracking_mode = 1'b0; max_ready = 1'b0;
    idle(); idle();
    checks += 6;
    if (static_write_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b, expected 0", static_write_en); end
    if (static_write_address !== 19'd0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", static_write_address); end
    if (static_write_data !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d, expected 0", static_write_data); end
    if (static_bram_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b, expected 0", static_bram_rdy); end
    if (sof_err !== 1'b0) begin errors++; $display("FAIL reset_sof_err: got %b, expected 0", sof_err); end
    if (frames_dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %0d, expected 0", frames_dropped); end
    rst = 1'b0;
  endtask

  task automatic test_contiguous(input bit gaps, input string nm);
    int w0 = n_writes;
    send_frame(gaps);
    checks++;
    if (static_bram_rdy !== 1'b0) begin errors++; $display("FAIL %s_rdy_early: got %b, expected 0", nm, static_bram_rdy); end
    idle();
    checks++;
    if (static_bram_rdy !== 1'b1) begin errors++; $display("FAIL %s_rdy_rise: got %b, expected 1", nm, static_bram_rdy); end
    idle(); idle();
    checks += 3;
    if (static_bram_rdy !== 1'b0) begin errors++; $display("FAIL %s_rdy_exit: got %b, expected 0", nm, static_bram_rdy); end
    if (n_writes - w0 != N) begin errors++; $display("FAIL %s_nwrites: got %0d, expected %0d", nm, n_writes - w0, N); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing: got %0d pending, expected 0", nm, exp_q.size()); end
  endtask

  task automatic test_sof_restart();
    int w0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      expect_wr(i, i % 16);
      drive(1'b1, 4'(i % 16), i == 0);
      checks++;
      if (sof_err !== 1'b0) begin errors++; $display("FAIL restart_sof_err_pre: got %b, expected 0", sof_err); end
    end
    expect_wr(0, 7);
    drive(1'b1, 4'd7, 1'b1);
    checks++;
    if (sof_err !== 1'b1) begin errors++; $display("FAIL restart_sof_err: got %b, expected 1", sof_err); end
    for (int j = 1; j < N; j++) begin
      expect_wr(j, (j + 7) % 16);
      drive(1'b1, 4'((j + 7) % 16), 1'b0);
      if (j == 1) begin
        checks++;
        if (sof_err !== 1'b0) begin errors++; $display("FAIL restart_sof_err_pulse: got %b, expected 0", sof_err); end
      end
    end
    checks++;
    if (static_bram_rdy !== 1'b0) begin errors++; $display("FAIL restart_rdy_early: got %b, expected 0", static_bram_rdy); end
    idle();
    checks++;
    if (static_bram_rdy !== 1'b1) begin errors++; $display("FAIL restart_rdy: got %b, expected 1", static_bram_rdy); end
    idle(); idle();
    checks += 2;
    if (n_writes - w0 != 10 + N) begin errors++; $display("FAIL restart_nwrites: got %0d, expected %0d", n_writes - w0, 10 + N); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL restart_missing: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_tracking_hold();
    tracking_mode = 1'b1; max_ready = 1'b1;
    send_frame(1'b0);
    idle();
    checks++;
    if (static_bram_rdy !== 1'b1) begin errors++; $display("FAIL track_guard0: got %b, expected 1", static_bram_rdy); end
    idle();
    checks++;
    if (static_bram_rdy !== 1'b1) begin errors++; $display("FAIL track_guard1: got %b, expected 1", static_bram_rdy); end
    idle();
    checks++;
    if (static_bram_rdy !== 1'b0) begin errors++; $display("FAIL track_fall: got %b, expected 0", static_bram_rdy); end
    // In IDLE: a non-sof pixel is discarded, an sof pixel starts a clean capture.
    drive(1'b1, 4'd9, 1'b0);
    expect_wr(0, 5);
    drive(1'b1, 4'd5, 1'b1);
    checks++;
    if (sof_err !== 1'b0) begin errors++; $display("FAIL track_idle_sof_err: got %b, expected 0", sof_err); end
    idle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL track_idle_write: got %0d pending, expected 0", exp_q.size()); end
    rst = 1'b1; idle(); rst = 1'b0;
  endtask

  task automatic test_drop();
    tracking_mode = 1'b1; max_ready = 1'b0;
    send_frame(1'b0);
    repeat (6) idle();
    checks++;
    if (static_bram_rdy !== 1'b1) begin errors++; $display("FAIL drop_hold_rdy: got %b, expected 1", static_bram_rdy); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'(k), 1'b1);
      drive(1'b1, 4'(k + 3), 1'b0);
    end
    idle();
    checks += 2;
    if (frames_dropped !== 16'(3 * DROP_EN)) begin errors++; $display("FAIL drop_count: got %0d, expected %0d", frames_dropped, 3 * DROP_EN); end
    if (static_bram_rdy !== 1'b1) begin errors++; $display("FAIL drop_rdy_held: got %b, expected 1", static_bram_rdy); end
    // sof in the exit cycle still belongs to HOLD
    max_ready = 1'b1;
    drive(1'b1, 4'd3, 1'b1);
    max_ready = 1'b0; tracking_mode = 1'b0;
    checks += 2;
    if (static_bram_rdy !== 1'b0) begin errors++; $display("FAIL drop_exit_rdy: got %b, expected 0", static_bram_rdy); end
    if (frames_dropped !== 16'(4 * DROP_EN)) begin errors++; $display("FAIL drop_exit_count: got %0d, expected %0d", frames_dropped, 4 * DROP_EN); end
    idle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_rst_mid();
    int w0 = n_writes;
    for (int i = 0; i < 20; i++) begin
      expect_wr(i, i % 16);
      drive(1'b1, 4'(i % 16), i == 0);
    end
    rst = 1'b1;
    drive(1'b1, 4'd4, 1'b0);
    rst = 1'b0;
    for (int i = 21; i < 26; i++) drive(1'b1, 4'(i % 16), 1'b0);
    checks += 3;
    if (n_writes - w0 != 20) begin errors++; $display("FAIL rstmid_nwrites: got %0d, expected 20", n_writes - w0); end
    if (static_bram_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %b, expected 0", static_bram_rdy); end
    if (frames_dropped !== 16'd0) begin errors++; $display("FAIL rstmid_dropped: got %0d, expected 0", frames_dropped); end
    test_contiguous(1'b0, "rstmid_frame");
  endtask

  initial begin
    pix_valid = 1'b0; pix_data = 4'd0; pix_sof = 1'b0;
    test_reset();
    test_contiguous(1'b0, "contig");
    test_contiguous(1'b1, "gapped");
    test_sof_restart();
    test_tracking_hold();
    test_drop();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
